// File: rtl/axi4_lite_slave_reg_block_if.sv
// ============================================================================
// axi4_lite_slave_reg_block_if
//
// AXI4-Lite bus bundle connecting one manager to axi4_lite_slave_reg_block.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R). Clock and reset are
// not part of the bundle and stay plain ports on the modules.
//
// Parameters:
//   ADDR_WIDTH - byte address width
//   DATA_WIDTH - data width (32 or 64)
//
// Modports:
//   master - manager side: drives the valid/address/data/ready-for-response
//   slave  - register block side: drives the ready and response signals
// ============================================================================
interface axi4_lite_slave_reg_block_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    // Write data channel
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    // Write response channel
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    // Read address channel
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    // Read data channel
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr, arprot,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr, arprot,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_slave_reg_block.sv
// ============================================================================
// axi4_lite_slave_reg_block
//
// AXI4-Lite slave endpoint backed by a bank of general-purpose word registers.
// One write and one read may be outstanding at a time; the two channels run
// independently and may complete in the same cycle (a read then sees the
// register value from before the write).
//
// Optional feature (compile-time macro AXI4_LITE_SLV_REG_SLVERR_EN):
//   defined   - out-of-range accesses answer SLVERR (2'b10)
//   undefined - out-of-range accesses answer OKAY  (2'b00)
//   Out-of-range writes are always dropped, out-of-range reads return 0.
//
// Ports:
//   clk - single clock
//   rst - synchronous, active-high reset
//   bus - AXI4-Lite slave modport (AW/W/B/AR/R channels)
// ============================================================================
module axi4_lite_slave_reg_block #(
    parameter int G_AXI4_LITE_ADDR_WIDTH = 8,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32,
    parameter int G_NB_REGS              = 16
) (
    input logic                          clk,
    input logic                          rst,
    axi4_lite_slave_reg_block_if.slave   bus
);

    localparam int NB_BYTES   = G_AXI4_LITE_DATA_WIDTH / 8;
    localparam int ADDR_LSB   = $clog2(NB_BYTES);
    localparam int IDX_W      = (G_NB_REGS > 1) ? $clog2(G_NB_REGS) : 1;
    localparam int BANK_BYTES = G_NB_REGS * NB_BYTES;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI4_LITE_SLV_REG_SLVERR_EN
    localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

    logic [G_AXI4_LITE_DATA_WIDTH-1:0] regs [G_NB_REGS];

    logic             wr_start;
    logic             wr_fire;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_start;
    logic             rd_fire;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;

    // Protection bits carry no meaning for this block.
    logic unused_prot;
    assign unused_prot = ^{bus.awprot, bus.arprot, RESP_SLVERR};

    // A transaction is started (ready raised) when both request channels are
    // valid and nothing is outstanding; it completes on the following cycle
    // when ready meets the still-held valid.
    assign wr_start = bus.awvalid && bus.wvalid && !bus.awready && !bus.bvalid;
    assign wr_fire  = bus.awvalid && bus.awready && bus.wvalid && bus.wready;
    assign rd_start = bus.arvalid && !bus.arready && !bus.rvalid;
    assign rd_fire  = bus.arvalid && bus.arready;

    // One extra bit on the compare so a bank that fills the whole address
    // space does not wrap its limit to zero.
    assign wr_in_range = {1'b0, bus.awaddr} < (G_AXI4_LITE_ADDR_WIDTH + 1)'(BANK_BYTES);
    assign rd_in_range = {1'b0, bus.araddr} < (G_AXI4_LITE_ADDR_WIDTH + 1)'(BANK_BYTES);
    assign wr_idx      = bus.awaddr[ADDR_LSB +: IDX_W];
    assign rd_idx      = bus.araddr[ADDR_LSB +: IDX_W];

    // ------------------------------------------------------------------------
    // Write channel handshake and response
    // ------------------------------------------------------------------------
    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the pre-edge value of the others (this is what makes a same-cycle read
    // return the old register contents).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
        end else begin
            bus.awready <= wr_start;
            bus.wready  <= wr_start;
            if (wr_fire) begin
                bus.bvalid <= 1'b1;
                bus.bresp  <= wr_in_range ? RESP_OKAY : RESP_OOR;
            end else if (bus.bready) begin
                bus.bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register bank with byte-strobed writes
    // ------------------------------------------------------------------------
    // NOTE: the bank is explicitly cleared on reset because software relies on
    // reading zeros after reset; this keeps it in flops rather than a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < G_NB_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_fire && wr_in_range) begin
            for (int b = 0; b < NB_BYTES; b++) begin
                if (bus.wstrb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read channel handshake and registered data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= RESP_OKAY;
        end else begin
            bus.arready <= rd_start;
            if (rd_fire) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= rd_in_range ? regs[rd_idx] : '0;
                bus.rresp  <= rd_in_range ? RESP_OKAY : RESP_OOR;
            end else if (bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_reg_block.sv
// ============================================================================
// tb_axi4_lite_slave_reg_block
//
// Self-checking bench for axi4_lite_slave_reg_block (32-bit data, 16 regs,
// 8-bit addresses). Honours AXI4_LITE_SLV_REG_SLVERR_EN for the expected
// out-of-range response code.
// ============================================================================
module tb_axi4_lite_slave_reg_block;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = 16;

`ifdef AXI4_LITE_SLV_REG_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_lite_slave_reg_block_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_slave_reg_block #(
        .G_AXI4_LITE_ADDR_WIDTH(AW),
        .G_AXI4_LITE_DATA_WIDTH(DW),
        .G_NB_REGS             (NB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- reference model: a plain array of words ----------------
    logic [31:0] model [NB];

    function automatic bit in_range(input logic [7:0] addr);
        return int'(addr) < NB * 4;
    endfunction

    function automatic logic [1:0] model_resp(input logic [7:0] addr);
        return in_range(addr) ? 2'b00 : OOR_RESP;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        return in_range(addr) ? model[int'(addr) / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] w;
        if (in_range(addr)) begin
            w = model[int'(addr) / 4];
            for (int b = 0; b < 4; b++)
                if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
            model[int'(addr) / 4] = w;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) model[i] = 32'h0;
    endtask

    // ---------------- bus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int waited = 0;
        resp        = 2'bxx;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        while (!bus.awready && waited < 20) begin
            tick();
            waited++;
        end
        check("wr_accept_timeout", bus.awready, 1'b1);
        if (!bus.awready) begin
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            return;
        end
        check("wready_with_awready", bus.wready, 1'b1);
        check("bvalid_not_early", bus.bvalid, 1'b0);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("awready_one_cycle", bus.awready, 1'b0);
        check("bvalid_next_cycle", bus.bvalid, 1'b1);
        resp = bus.bresp;
        tick();
        check("bvalid_drop", bus.bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int waited = 0;
        data        = 'x;
        resp        = 2'bxx;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        while (!bus.arready && waited < 20) begin
            tick();
            waited++;
        end
        check("rd_accept_timeout", bus.arready, 1'b1);
        if (!bus.arready) begin
            bus.arvalid = 1'b0;
            return;
        end
        check("rvalid_not_early", bus.rvalid, 1'b0);
        tick();
        bus.arvalid = 1'b0;
        check("arready_one_cycle", bus.arready, 1'b0);
        check("rvalid_next_cycle", bus.rvalid, 1'b1);
        data = bus.rdata;
        resp = bus.rresp;
        tick();
        check("rvalid_drop", bus.rvalid, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_write;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit is_write, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_resp, input string name);
        vec_t v;
        v.is_write  = is_write;
        v.addr      = addr;
        v.data      = data;
        v.strb      = strb;
        v.exp_rdata = exp_rdata;
        v.exp_resp  = exp_resp;
        v.name      = name;
        vecs.push_back(v);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          waited;

        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b000;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b000;
        bus.rready  = 1'b0;
        model_clear();

        // ---- reset state ----
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready",  bus.wready,  1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_bvalid",  bus.bvalid,  1'b0);
        check("rst_rvalid",  bus.rvalid,  1'b0);
        check("rst_bresp",   bus.bresp,   2'b00);
        check("rst_rresp",   bus.rresp,   2'b00);
        check("rst_rdata",   bus.rdata,   32'h0);

        // ---- table-driven directed vectors ----
        add_vec(0, 8'h00, 32'h0,        4'h0, 32'h0,        2'b00,    "rd_00_after_reset");
        add_vec(0, 8'h3C, 32'h0,        4'h0, 32'h0,        2'b00,    "rd_3c_after_reset");
        add_vec(1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00,    "wr_08_full");
        add_vec(0, 8'h08, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00,    "rd_08");
        add_vec(1, 8'h04, 32'h11223344, 4'hF, 32'h0,        2'b00,    "wr_04_full");
        add_vec(1, 8'h04, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00,    "wr_04_strb5");
        add_vec(0, 8'h04, 32'h0,        4'h0, 32'h11BB33DD, 2'b00,    "rd_04_merged");
        add_vec(1, 8'h80, 32'hFFFFFFFF, 4'hF, 32'h0,        OOR_RESP, "wr_80_oor");
        add_vec(0, 8'h80, 32'h0,        4'h0, 32'h0,        OOR_RESP, "rd_80_oor");
        add_vec(0, 8'h00, 32'h0,        4'h0, 32'h0,        2'b00,    "rd_00_untouched");
        add_vec(0, 8'h09, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00,    "rd_09_unaligned");
        add_vec(1, 8'h3F, 32'h12345678, 4'h8, 32'h0,        2'b00,    "wr_3f_top_byte");
        add_vec(0, 8'h3C, 32'h0,        4'h0, 32'h12000000, 2'b00,    "rd_3c_top_byte");
        add_vec(0, 8'h40, 32'h0,        4'h0, 32'h0,        OOR_RESP, "rd_40_first_oor");

        foreach (vecs[i]) begin
            if (vecs[i].is_write) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                check({vecs[i].name, "_bresp"}, rs, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, rd, rs);
                check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
                check({vecs[i].name, "_rresp"}, rs, vecs[i].exp_resp);
            end
        end

        // ---- AW alone must wait for W; held-off B stays stable ----
        bus.awaddr  = 8'h10;
        bus.awvalid = 1'b1;
        bus.bready  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("aw_alone_no_awready", bus.awready, 1'b0);
            check("aw_alone_no_wready",  bus.wready,  1'b0);
        end
        bus.wdata  = 32'hCAFEF00D;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        waited = 0;
        while (!bus.awready && waited < 20) begin
            tick();
            waited++;
        end
        check("aw_w_accept", bus.awready, 1'b1);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        model_write(8'h10, 32'hCAFEF00D, 4'hF);
        for (int c = 0; c < 3; c++) begin
            check("bvalid_held", bus.bvalid, 1'b1);
            check("bresp_held",  bus.bresp,  2'b00);
            tick();
        end
        check("bvalid_held_last", bus.bvalid, 1'b1);
        bus.bready = 1'b1;
        tick();
        check("bvalid_released", bus.bvalid, 1'b0);
        do_read(8'h10, rd, rs);
        check("rd_10_after_wait", rd, model_read(8'h10));

        // ---- same-cycle read and write to 0x0C ----
        do_write(8'h0C, 32'h1, 4'hF, rs);
        model_write(8'h0C, 32'h1, 4'hF);
        bus.awaddr  = 8'h0C;
        bus.wdata   = 32'h2;
        bus.wstrb   = 4'hF;
        bus.araddr  = 8'h0C;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        bus.bready  = 1'b1;
        bus.rready  = 1'b1;
        waited = 0;
        while (!bus.arready && waited < 20) begin
            tick();
            waited++;
        end
        check("same_cycle_arready", bus.arready, 1'b1);
        check("same_cycle_awready", bus.awready, 1'b1);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        check("same_cycle_rvalid", bus.rvalid, 1'b1);
        check("same_cycle_bvalid", bus.bvalid, 1'b1);
        check("same_cycle_old_value", bus.rdata, 32'h1);
        tick();
        model_write(8'h0C, 32'h2, 4'hF);
        do_read(8'h0C, rd, rs);
        check("same_cycle_new_value", rd, 32'h2);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 150; n++) begin
            logic [7:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 8'($urandom_range(0, 8'h5F));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, rs);
                check("rand_bresp", rs, model_resp(a));
                model_write(a, d, s);
            end else begin
                do_read(a, rd, rs);
                check("rand_rdata", rd, model_read(a));
                check("rand_rresp", rs, model_resp(a));
            end
        end

        // ---- reset in the middle of a pending read response ----
        do_write(8'h08, 32'h55AA55AA, 4'hF, rs);
        model_write(8'h08, 32'h55AA55AA, 4'hF);
        bus.araddr  = 8'h08;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;
        waited = 0;
        while (!bus.arready && waited < 20) begin
            tick();
            waited++;
        end
        check("rst_mid_accept", bus.arready, 1'b1);
        tick();
        bus.arvalid = 1'b0;
        check("rst_mid_rvalid", bus.rvalid, 1'b1);
        check("rst_mid_rdata",  bus.rdata,  32'h55AA55AA);
        tick();
        check("rst_mid_rvalid_hold", bus.rvalid, 1'b1);
        check("rst_mid_rdata_hold",  bus.rdata,  32'h55AA55AA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("rst_mid_rvalid_abort", bus.rvalid, 1'b0);
        check("rst_mid_bvalid_abort", bus.bvalid, 1'b0);
        do_read(8'h08, rd, rs);
        check("rst_mid_reg_cleared", rd, 32'h0);
        do_read(8'h10, rd, rs);
        check("rst_mid_reg10_cleared", rd, model_read(8'h10));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
